// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants for the instruction fetch stage
package rv_fetch_pkg;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [1:0] ST_RUN   = 2'b00;
   localparam logic [1:0] ST_DRAIN = 2'b01;
   localparam logic [1:0] ST_HALT  = 2'b10;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/grant/response bus
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (output imem_req_o, imem_addr_o,
                   input  imem_gnt_i, imem_rvalid_i, imem_rdata_i);
   modport slave  (input  imem_req_o, imem_addr_o,
                   output imem_gnt_i, imem_rvalid_i, imem_rdata_i);
endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - prefetch FIFO of {pc, instr} entries with clear
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   clear,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign do_push   = push && (count != FULL_C) && !clear;
   assign do_pop    = pop && !empty && !clear;
   assign head_data = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, imem requests, prefetch FIFO, IF/ID register
// Optional FETCH_MISALIGN_CHECK_EN halts on misaligned redirect targets.
module fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pc_en_i,
   input  logic               if_id_en_i,
   input  logic               if_id_flush_i,
   input  logic               pc_next_sel_i,
   input  logic [31:0]        branch_target_i,
   fetch_unit_if.master       imem,
   output logic [31:0]        instruction_o,
   output logic [31:0]        pc_id_o,
   output logic               instr_valid_o,
   output logic               fetch_stall_o
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic               misaligned_o
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [1:0]    state;
   logic          started;
   logic [31:0]   pc;
   logic [31:0]   target;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] kill_cnt;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] committed;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] kill_nxt;
   logic [CW-1:0] redirect_kill;
   logic          fifo_empty;
   logic [63:0]   fifo_head;
   logic          gnt_fire;
   logic          rsp_live;
   logic          rsp_kill;
   logic          pop;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic target_bad;
   assign target     = branch_target_i;
   assign target_bad = (branch_target_i[1:0] != 2'b00);
`else
   assign target = branch_target_i & 32'hFFFF_FFFC;
`endif

   // A pop this cycle frees a slot, so count it as credit to sustain 1 instr/cycle.
   assign pop       = if_id_en_i && !if_id_flush_i && !fifo_empty;
   assign committed = fifo_count - CW'(pop) + outstanding;

   assign imem.imem_req_o  = started && (state == ST_RUN) && pc_en_i && (committed < DEPTH_C);
   assign imem.imem_addr_o = pc;

   assign gnt_fire = imem.imem_req_o && imem.imem_gnt_i;
   assign rsp_live = imem.imem_rvalid_i && (state == ST_RUN) && (outstanding != '0);
   assign rsp_kill = imem.imem_rvalid_i && (state != ST_RUN) && (kill_cnt != '0);

   // Responses return in order, so the oldest outstanding address trails pc.
   assign rsp_pc = pc - (32'(outstanding) << 2);

   assign outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(rsp_live);
   assign kill_nxt        = kill_cnt - CW'(rsp_kill);
   assign redirect_kill   = (state == ST_RUN) ? outstanding_nxt : kill_nxt;

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_live),
      .push_data ({rsp_pc, imem.imem_rdata_i}),
      .pop       (pop),
      .clear     (pc_next_sel_i),
      .head_data (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         started     <= 1'b0;
         pc          <= RESET_PC;
         outstanding <= '0;
         kill_cnt    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         misaligned_o <= 1'b0;
`endif
      end else begin
         started <= 1'b1;
         if (pc_next_sel_i) begin
            pc          <= target;
            outstanding <= '0;
            kill_cnt    <= redirect_kill;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_o <= target_bad;
            if (target_bad) state <= ST_HALT;
            else            state <= (redirect_kill != '0) ? ST_DRAIN : ST_RUN;
`else
            state <= (redirect_kill != '0) ? ST_DRAIN : ST_RUN;
`endif
         end else begin
            if (gnt_fire) pc <= pc + 32'd4;
            outstanding <= outstanding_nxt;
            kill_cnt    <= kill_nxt;
            if ((state == ST_DRAIN) && (kill_nxt == '0)) state <= ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction_o <= NOP_INSTR;
         pc_id_o       <= '0;
         instr_valid_o <= 1'b0;
         fetch_stall_o <= 1'b0;
      end else if (if_id_flush_i) begin
         instruction_o <= NOP_INSTR;
         instr_valid_o <= 1'b0;
         fetch_stall_o <= 1'b0;
      end else if (if_id_en_i) begin
         if (!fifo_empty) begin
            instruction_o <= fifo_head[31:0];
            pc_id_o       <= fifo_head[63:32];
            instr_valid_o <= 1'b1;
            fetch_stall_o <= 1'b0;
         end else begin
            instruction_o <= NOP_INSTR;
            instr_valid_o <= 1'b0;
            fetch_stall_o <= 1'b1;
         end
      end else begin
         fetch_stall_o <= 1'b0;
      end
   end
endmodule
